stall_sequencer: RTL and testbench

//  Multi-cycle pipeline stall/flush sequencer driven by decode-stage hazard signals.
//  - Detects load-use hazards and control transfers (branch/jal/jalr).
//  - Converts each detected hazard into a fixed-length sequence of PC hold, IF/ID hold/flush and ID/EX bubble enables.
//  - Sits between decode and the IF/ID, ID/EX and PC registers.

---
 rtl/stall_sequencer.sv | 81 ++++++++
 tb/tb_stall_sequencer.sv | 111 +++++++++++
 2 files changed

// File: rtl/stall_sequencer.sv
// stall_sequencer: turns decode-stage hazards into fixed-length PC hold / IF/ID flush / ID/EX bubble sequences.
// Optional macro STALL_STATS_EN builds a 32-bit stall_cycles counter; otherwise stall_cycles is tied to zero.
module stall_sequencer #(
   parameter int LOADUSE_PENALTY = 1,
   parameter int BRANCH_PENALTY  = 2,
   parameter int JUMP_PENALTY    = 1,
   parameter int CNT_W           = 3
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        branch,
   input  logic        jal,
   input  logic        jalr,
   input  logic        exMem_mem_reg,
   input  logic [4:0]  exMem_write_reg,
   input  logic [4:0]  ifEx_read_reg1,
   input  logic [4:0]  ifEx_read_reg2,
   output logic        pc_write,
   output logic        ifid_write,
   output logic        ifid_flush,
   output logic        idex_bubble,
   output logic        busy,
   output logic [31:0] stall_cycles
);
   localparam logic [1:0] IDLE       = 2'd0;
   localparam logic [1:0] LU_STALL   = 2'd1;
   localparam logic [1:0] CTRL_STALL = 2'd2;
   localparam int PMAX = (1 << CNT_W) - 1;

   if (LOADUSE_PENALTY > PMAX || BRANCH_PENALTY > PMAX || JUMP_PENALTY > PMAX) begin : g_bad_penalty
      $error("stall_sequencer: penalty exceeds 2**CNT_W-1");
   end

   logic [1:0]       state;
   logic [CNT_W-1:0] cnt, p;
   logic             idle, ctrl_hz, lu_hz, det_ctrl, det_lu, lu_on, ctrl_on;

   assign idle     = state == IDLE;
   assign ctrl_hz  = idle && !reset && (branch || jal || jalr);
   assign lu_hz    = idle && !reset && exMem_mem_reg && exMem_write_reg != 5'd0 &&
                     (exMem_write_reg == ifEx_read_reg1 || exMem_write_reg == ifEx_read_reg2);
   // a control transfer squashes any load-use hazard seen in the same cycle
   assign p        = ctrl_hz ? (branch ? CNT_W'(BRANCH_PENALTY) : CNT_W'(JUMP_PENALTY)) :
                     lu_hz   ? CNT_W'(LOADUSE_PENALTY) : '0;
   assign det_ctrl = ctrl_hz && p != '0;
   assign det_lu   = !ctrl_hz && lu_hz && p != '0;
   assign lu_on    = !reset && (det_lu || state == LU_STALL);
   assign ctrl_on  = !reset && (det_ctrl || state == CTRL_STALL);

   assign pc_write    = !(lu_on || ctrl_on);
   assign ifid_write  = !lu_on;
   assign ifid_flush  = ctrl_on;
   assign idex_bubble = lu_on || ctrl_on;
   assign busy        = !idle;

   // the detection cycle is stall cycle 1, so cnt counts the remaining P-1 cycles down to zero
   always_ff @(posedge clk) begin
      if (reset) begin
         state <= IDLE;
         cnt   <= '0;
      end else if (idle) begin
         if (p > CNT_W'(1)) begin
            state <= det_ctrl ? CTRL_STALL : LU_STALL;
            cnt   <= p - CNT_W'(2);
         end
      end else if (cnt == '0) begin
         state <= IDLE;
      end else begin
         cnt <= cnt - CNT_W'(1);
      end
   end

`ifdef STALL_STATS_EN
   always_ff @(posedge clk) begin
      if (reset) stall_cycles <= 32'd0;
      else if (!pc_write) stall_cycles <= stall_cycles + 32'd1;
   end
`else
   assign stall_cycles = 32'd0;
`endif
endmodule

// File: tb/tb_stall_sequencer.sv
// tb_stall_sequencer: directed T1-T6 steps plus random traffic, checked against a remaining-cycles model.
module tb_stall_sequencer;
   localparam int LP = 1, BP = 2, JP = 1;

   logic        clk = 1'b0;
   logic        reset, branch, jal, jalr, mem_reg;
   logic [4:0]  wr, rd1, rd2;
   logic        pc_write, ifid_write, ifid_flush, idex_bubble, busy;
   logic [31:0] stall_cycles;

   int          checks = 0, errors = 0;
   int          rem = 0;
   bit          lu_kind = 1'b0;
   int unsigned stats = 0;

   always #5 clk = ~clk;

   stall_sequencer #(.LOADUSE_PENALTY(LP), .BRANCH_PENALTY(BP), .JUMP_PENALTY(JP), .CNT_W(3)) dut (
      .clk(clk), .reset(reset), .branch(branch), .jal(jal), .jalr(jalr),
      .exMem_mem_reg(mem_reg), .exMem_write_reg(wr), .ifEx_read_reg1(rd1), .ifEx_read_reg2(rd2),
      .pc_write(pc_write), .ifid_write(ifid_write), .ifid_flush(ifid_flush),
      .idex_bubble(idex_bubble), .busy(busy), .stall_cycles(stall_cycles)
   );

   task automatic check(string tag, logic [31:0] got, logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   function automatic logic [31:0] stats_exp(int unsigned s);
`ifdef STALL_STATS_EN
      return s;
`else
      return 32'd0;
`endif
   endfunction

   // one clock: drive, compare at the falling edge, then advance the model across the rising edge
   task automatic cyc(string tag, bit r, bit b, bit j, bit jr, bit m, logic [4:0] w, logic [4:0] a, logic [4:0] c);
      int p;
      bit k, act, st;
      reset = r; branch = b; jal = j; jalr = jr; mem_reg = m; wr = w; rd1 = a; rd2 = c;
      @(negedge clk);
      p = 0;
      k = lu_kind;
      act = rem > 0;
      if (!act && !r) begin
         if (b || j || jr) begin p = b ? BP : JP; k = 1'b0; end
         else if (m && w != 5'd0 && (w == a || w == c)) begin p = LP; k = 1'b1; end
         act = p > 0;
      end
      st = act && !r;
      check({tag, ".pc_write"},    32'(pc_write),    32'(!st));
      check({tag, ".ifid_write"},  32'(ifid_write),  32'(!(st && k)));
      check({tag, ".ifid_flush"},  32'(ifid_flush),  32'(st && !k));
      check({tag, ".idex_bubble"}, 32'(idex_bubble), 32'(st));
      check({tag, ".busy"},        32'(busy),        32'(rem > 0));
      check({tag, ".stall_cycles"}, stall_cycles, stats_exp(stats));
      if (r) begin rem = 0; stats = 0; end
      else begin
         if (st) stats++;
         if (rem > 0) rem--;
         else if (p > 0) begin rem = p - 1; lu_kind = k; end
      end
      @(posedge clk);
      #1;
   endtask

   initial begin
      cyc("rst0", 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("rst1", 1, 1, 0, 0, 1, 5, 5, 0);
      cyc("T1a", 0, 0, 0, 0, 1, 5, 5, 0);
      cyc("T1b", 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("T1c", 0, 0, 0, 0, 1, 7, 3, 7);
      cyc("T2a", 0, 0, 0, 0, 1, 0, 0, 0);
      cyc("T2b", 0, 0, 0, 0, 1, 0, 0, 0);
      cyc("T3a", 0, 1, 0, 0, 0, 0, 0, 0);
      cyc("T3b", 0, 0, 0, 0, 1, 4, 4, 4);
      cyc("T3c", 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("jal", 0, 0, 1, 0, 0, 0, 0, 0);
      cyc("jalr", 0, 0, 0, 1, 0, 0, 0, 0);
      cyc("T4a", 0, 1, 0, 0, 1, 9, 9, 9);
      cyc("T4b", 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("T4c", 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("T5a", 0, 1, 0, 0, 0, 0, 0, 0);
      cyc("T5b", 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("T5c", 0, 0, 0, 0, 0, 0, 0, 0);
      check("T5.stall_cycles_zero", stall_cycles, 32'd0);
      cyc("T6r", 1, 0, 0, 0, 0, 0, 0, 0);
      cyc("T6a", 0, 1, 0, 0, 0, 0, 0, 0);
      cyc("T6b", 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("T6c", 0, 1, 0, 0, 0, 0, 0, 0);
      cyc("T6d", 0, 0, 0, 0, 0, 0, 0, 0);
      cyc("T6e", 0, 0, 0, 0, 1, 3, 0, 3);
`ifdef STALL_STATS_EN
      check("T6.total", stall_cycles, 32'd5);
`else
      check("T6.total", stall_cycles, 32'd0);
`endif
      for (int i = 0; i < 400; i++) begin
         cyc("rand", $urandom_range(0, 99) < 3, $urandom_range(0, 9) == 0, $urandom_range(0, 11) == 0,
             $urandom_range(0, 11) == 0, $urandom_range(0, 1) == 1, 5'($urandom_range(0, 3)),
             5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)));
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
